gate_pipe: RTL and testbench

Parametrised, pipelined successor to the 2-input `andport` gate. It applies one of eight selectable bitwise or reduction logic operations to two WIDTH-bit operands. The result is delivered through a 2-stage valid/ready pipeline, and a saturating counter records how often the accepted output value changes. It serves as the standard registered logic primitive for datapath glue and as a self-checking demo block.

---
 rtl/gate_pkg.sv | 47 ++++
 rtl/gate_stage.sv | 35 +++
 rtl/gate_pipe.sv | 77 +++++++
 tb/tb_gate_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// gate_pkg: operation encodings and the combinational evaluator shared by gate_pipe.
// Revision: 1.0
`default_nettype none

package gate_pkg;

  localparam int OP_W  = 3;
  // Widest operand that gate_eval supports. Narrower callers zero-extend and truncate.
  localparam int MAX_W = 64;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_RAND = 3'b110,
    OP_ROR  = 3'b111
  } gate_op_e;

  // w is the live operand width. Reductions only look at a[w-1:0].
  function automatic logic [MAX_W-1:0] gate_eval(input gate_op_e op,
                                                 input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] res;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    res  = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_RAND: res[0] = &(a | ~mask);
      OP_ROR:  res[0] = |(a & mask);
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_stage.sv
// gate_stage: single valid/ready register slice with a pass-through ready.
// Revision: 1.0
`default_nettype none

module gate_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // The slice can load whenever it is empty or is being drained this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gate_pipe.sv
// gate_pipe: two-stage valid/ready logic-operation pipeline with a saturating output-change counter.
// Revision: 1.0
`default_nettype none

module gate_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] change_cnt
);

  localparam int                P1_W    = OP_W + 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid;
  logic             s2_ready;
  logic [P1_W-1:0]  s1_data;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  gate_op_e         s1_op;
  logic [WIDTH-1:0] s2_in;
  logic [WIDTH-1:0] last_accepted;

  gate_stage #(.W(P1_W)) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({op, a, b}),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign s1_op = gate_op_e'(s1_data[P1_W-1 -: OP_W]);
  assign s1_a  = s1_data[2*WIDTH-1 -: WIDTH];
  assign s1_b  = s1_data[WIDTH-1:0];
  assign s2_in = WIDTH'(gate_eval(s1_op, MAX_W'(s1_a), MAX_W'(s1_b), WIDTH));

  gate_stage #(.W(WIDTH)) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_cnt    <= '0;
      last_accepted <= '0;
    end else if (out_valid && out_ready) begin
      last_accepted <= out;
      if (out != last_accepted && change_cnt != CNT_MAX) begin
        change_cnt <= change_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_pipe.sv
// tb_gate_pipe: directed, table-driven bench for gate_pipe (8-bit, 1-bit and 2-bit-counter instances).
// Revision: 1.0
`default_nettype none

module tb_gate_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main stimulus, shared by the 16-bit-counter and 2-bit-counter instances.
  logic       in_valid = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid;
  logic [7:0] out;
  logic [15:0] cnt;
  logic       in_ready2, out_valid2;
  logic [7:0] out2;
  logic [1:0] cnt2;

  logic       w1_in_valid = 1'b0;
  logic [2:0] w1_op = 3'd0;
  logic [0:0] w1_a = 1'b0;
  logic [0:0] w1_b = 1'b0;
  logic       w1_out_ready = 1'b1;
  logic       w1_in_ready, w1_out_valid;
  logic [0:0] w1_out;
  logic [15:0] w1_cnt;

  int checks = 0;
  int failures = 0;

  gate_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out), .change_cnt(cnt)
  );

  gate_pipe #(.WIDTH(8), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .op(op),
    .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready), .out(out2), .change_cnt(cnt2)
  );

  gate_pipe #(.WIDTH(1), .CNT_W(16)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready), .op(w1_op),
    .a(w1_a), .b(w1_b), .out_valid(w1_out_valid), .out_ready(w1_out_ready), .out(w1_out),
    .change_cnt(w1_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    int         cnt;
  } vec_t;

  vec_t tv[10];

  logic [2:0] bp_op[4];
  logic [7:0] bp_a[4];
  logic [7:0] bp_b[4];
  logic [7:0] bp_exp[4];
  logic [1:0] w1_ab[4];
  logic [0:0] w1_exp[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int got;
    int ec;

    // Bitwise ops on F0/3C, then reductions; b is junk for reductions.
    tv[0] = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1};
    tv[1] = '{3'b001, 8'hF0, 8'h3C, 8'hFC, 2};
    tv[2] = '{3'b010, 8'hF0, 8'h3C, 8'hCC, 3};
    tv[3] = '{3'b011, 8'hF0, 8'h3C, 8'hCF, 4};
    tv[4] = '{3'b100, 8'hF0, 8'h3C, 8'h03, 5};
    tv[5] = '{3'b101, 8'hF0, 8'h3C, 8'h33, 6};
    tv[6] = '{3'b110, 8'hFF, 8'h55, 8'h01, 7};
    tv[7] = '{3'b110, 8'hFE, 8'hAA, 8'h00, 8};
    tv[8] = '{3'b111, 8'h00, 8'hFF, 8'h00, 8};
    tv[9] = '{3'b111, 8'h01, 8'h00, 8'h01, 9};

    bp_op[0] = 3'b010; bp_a[0] = 8'h12; bp_b[0] = 8'h34; bp_exp[0] = 8'h26;
    bp_op[1] = 3'b000; bp_a[1] = 8'hA5; bp_b[1] = 8'h0F; bp_exp[1] = 8'h05;
    bp_op[2] = 3'b100; bp_a[2] = 8'h0F; bp_b[2] = 8'hF0; bp_exp[2] = 8'h00;
    bp_op[3] = 3'b001; bp_a[3] = 8'h81; bp_b[3] = 8'h18; bp_exp[3] = 8'h99;

    w1_ab[0] = 2'b00; w1_exp[0] = 1'b0;
    w1_ab[1] = 2'b01; w1_exp[1] = 1'b0;
    w1_ab[2] = 2'b10; w1_exp[2] = 1'b0;
    w1_ab[3] = 2'b11; w1_exp[3] = 1'b1;

    // Reset state
    #2;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out", 64'(out), 64'd0);
    check("rst change_cnt", 64'(cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst in_ready", 64'(in_ready), 64'd1);

    // WIDTH=1 AND truth table
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        w1_in_valid = 1'b1;
        w1_a = w1_ab[i][1];
        w1_b = w1_ab[i][0];
      end else begin
        w1_in_valid = 1'b0;
      end
      #1;
      if (i >= 2) begin
        check($sformatf("w1 valid %0d", i - 2), 64'(w1_out_valid), 64'd1);
        check($sformatf("w1 out %0d", i - 2), 64'(w1_out), 64'(w1_exp[i-2]));
      end else begin
        check($sformatf("w1 early valid %0d", i), 64'(w1_out_valid), 64'd0);
      end
      tick();
    end
    check("w1 drained", 64'(w1_out_valid), 64'd0);
    check("w1 change_cnt", 64'(w1_cnt), 64'd1);

    // Table: one beat per cycle, out_ready high, result two edges later
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        in_valid = 1'b1; op = tv[i].op; a = tv[i].a; b = tv[i].b;
      end else begin
        in_valid = 1'b0; op = 3'd0; a = 8'd0; b = 8'd0;
      end
      #1;
      check($sformatf("tbl in_ready %0d", i), 64'(in_ready), 64'd1);
      if (i >= 2) begin
        check($sformatf("tbl valid %0d", i - 2), 64'(out_valid), 64'd1);
        check($sformatf("tbl out %0d", i - 2), 64'(out), 64'(tv[i-2].exp));
        check($sformatf("tbl c2 out %0d", i - 2), 64'(out2), 64'(tv[i-2].exp));
      end
      ec = (i >= 3) ? tv[i-3].cnt : 0;
      check($sformatf("tbl cnt %0d", i), 64'(cnt), 64'(ec));
      check($sformatf("tbl cnt2 %0d", i), 64'(cnt2), 64'((ec > 3) ? 3 : ec));
      tick();
    end
    check("tbl drained", 64'(out_valid), 64'd0);
    check("tbl final cnt", 64'(cnt), 64'd9);
    check("tbl final cnt2 saturated", 64'(cnt2), 64'd3);

    // Backpressure: out_ready low for 5 cycles while streaming 4 beats
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      out_ready = (cyc >= 5);
      if (idx < 4) begin
        in_valid = 1'b1; op = bp_op[idx]; a = bp_a[idx]; b = bp_b[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 2 && cyc < 5) begin
        check($sformatf("bp in_ready low %0d", cyc), 64'(in_ready), 64'd0);
        check($sformatf("bp hold valid %0d", cyc), 64'(out_valid), 64'd1);
        check($sformatf("bp hold out %0d", cyc), 64'(out), 64'(bp_exp[0]));
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp out %0d", got), 64'(out), 64'(bp_exp[got]));
        got++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    check("bp results delivered", 64'(got), 64'd4);
    check("bp beats accepted", 64'(idx), 64'd4);
    #1;
    check("bp no duplicate", 64'(out_valid), 64'd0);
    check("bp cnt", 64'(cnt), 64'd13);
    check("bp cnt2", 64'(cnt2), 64'd3);

    // Reset with both stages full
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; op = 3'b001; a = 8'h11; b = 8'h22;
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("full in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid-rst out_valid", 64'(out_valid), 64'd0);
    check("mid-rst cnt", 64'(cnt), 64'd0);
    check("mid-rst cnt2", 64'(cnt2), 64'd0);
    check("mid-rst out", 64'(out), 64'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'b000; a = 8'hFF; b = 8'h0F;
    #1;
    check("post-rst in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check("post-rst stage1 only", 64'(out_valid), 64'd0);
    tick();
    check("post-rst valid", 64'(out_valid), 64'd1);
    check("post-rst out", 64'(out), 64'h0F);
    tick();
    check("post-rst cnt", 64'(cnt), 64'd1);
    check("post-rst drained", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
